axi4lite_dht11_regs: RTL and testbench

- AXI4-Lite responder (slave) for the DHT11 tap peripheral; it is the far end of the bus master VIP agent.
- Provides four read/write software registers, matching the existing 0x0–0xC write/readback sequence.
- Adds read-only sensor registers, fed by the DHT11 capture logic.
- Sits between the block-design interconnect and the DHT11 core.

---
 rtl/dht11_axi_pkg.sv | 32 +++
 rtl/axi4lite_wr_hold.sv | 54 +++++
 rtl/axi4lite_dht11_regs.sv | 153 +++++++++++++++
 tb/tb_axi4lite_dht11_regs.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_axi_pkg.sv
// Shared definitions for the DHT11 AXI4-Lite register block.
package dht11_axi_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_SCR1   = 3'd1;
  localparam logic [2:0] REG_SCR2   = 3'd2;
  localparam logic [2:0] REG_SCR3   = 3'd3;
  localparam logic [2:0] REG_DATA   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [15:0] count;
    logic [13:0] rsvd;
    logic        err;
    logic        new_frame;
  } status_t;

  // Merge new_val into old_val one byte lane at a time under strb.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axi4lite_wr_hold.sv
// Single-entry AW/W holding pair; commit pulses the cycle both halves are held.
module axi4lite_wr_hold #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  bvalid,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic                  commit,
  output logic [ADDR_W-1:0]     hold_addr,
  output logic [DATA_W-1:0]     hold_data,
  output logic [DATA_W/8-1:0]   hold_strb
);

  logic aw_held;
  logic w_held;

  assign awready = en && !aw_held && !bvalid;
  assign wready  = en && !w_held && !bvalid;
  assign commit  = aw_held && w_held;

  // Capture each channel independently; release both once the write commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
      hold_strb <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_held   <= 1'b1;
        hold_addr <= awaddr;
      end
      if (wvalid && wready) begin
        w_held    <= 1'b1;
        hold_data <= wdata;
        hold_strb <= wstrb;
      end
    end
  end

endmodule

// File: rtl/axi4lite_dht11_regs.sv
// AXI4-Lite register block: CTRL + scratch RW, sensor DATA/STATUS read-only.
module axi4lite_dht11_regs
  import dht11_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [31:0]                     sensor_data,
  input  logic                            sensor_valid,
  input  logic                            sensor_err,
  output logic [31:0]                     ctrl
);

  logic                            rst_done;
  logic                            commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   hold_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   hold_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] hold_strb;
  logic [2:0]                      widx;
  logic [2:0]                      ridx;
  logic [31:0]                     regs_q [4];
  logic [31:0]                     data_q;
  status_t                         status_q;
  status_t                         status_d;
  logic [31:0]                     rd_word;
  logic                            ar_hs;
  logic                            unused_bits;

  assign widx          = hold_addr[4:2];
  assign ridx          = S_AXI_ARADDR[4:2];
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = rst_done && !S_AXI_RVALID;
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
  assign ctrl          = regs_q[0];
  assign unused_bits   = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], hold_addr[1:0]};

  axi4lite_wr_hold #(
    .ADDR_W (C_S_AXI_ADDR_WIDTH),
    .DATA_W (C_S_AXI_DATA_WIDTH)
  ) u_wr_hold (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .en        (rst_done),
    .bvalid    (S_AXI_BVALID),
    .awaddr    (S_AXI_AWADDR),
    .awvalid   (S_AXI_AWVALID),
    .awready   (S_AXI_AWREADY),
    .wdata     (S_AXI_WDATA),
    .wstrb     (S_AXI_WSTRB),
    .wvalid    (S_AXI_WVALID),
    .wready    (S_AXI_WREADY),
    .commit    (commit),
    .hold_addr (hold_addr),
    .hold_data (hold_data),
    .hold_strb (hold_strb)
  );

  // Keeps every READY low until the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

  // Write response: raised by the commit, held until BREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)          S_AXI_BVALID <= 1'b0;
    else if (commit)       S_AXI_BVALID <= 1'b1;
    else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
  end

  // RW registers; CTRL bit0 is cleared every cycle unless being written.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      regs_q[0][0] <= 1'b0;
      if (commit && !widx[2])
        regs_q[widx[1:0]] <= apply_wstrb(regs_q[widx[1:0]], hold_data, hold_strb);
    end
  end

  // STATUS next value: W1C first, sensor sets applied last so they win.
  always_comb begin
    status_d = status_q;
    if (commit && widx == REG_STATUS && hold_strb[0]) begin
      status_d.new_frame = status_q.new_frame & ~hold_data[0];
      status_d.err       = status_q.err & ~hold_data[1];
    end
    if (sensor_valid) begin
      status_d.new_frame = 1'b1;
      status_d.count     = status_q.count + 16'd1;
    end
    if (sensor_err) status_d.err = 1'b1;
  end

  // Sensor-facing state: latched frame and STATUS.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      data_q   <= '0;
      status_q <= '0;
    end else begin
      status_q <= status_d;
      if (sensor_valid) data_q <= sensor_data;
    end
  end

  // Read mux over the current (pre-update) register values.
  always_comb begin
    rd_word = '0;
    case (ridx)
      REG_CTRL, REG_SCR1, REG_SCR2, REG_SCR3: rd_word = regs_q[ridx[1:0]];
      REG_DATA:   rd_word = data_q;
      REG_STATUS: rd_word = status_q;
      default:    rd_word = '0;
    endcase
  end

  // Read data channel: registered on AR handshake, held until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_word;
    end else if (S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4lite_dht11_regs.sv
// Scoreboard bench for axi4lite_dht11_regs: driver queues expected responses, monitor checks them.
module tb_axi4lite_dht11_regs;
  import dht11_axi_pkg::*;

  logic        ACLK;
  logic        ARESETN;
  logic [4:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [4:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [31:0] sensor_data;
  logic        sensor_valid;
  logic        sensor_err;
  logic [31:0] ctrl;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int unsigned b_seen     = 0;
  int unsigned r_seen     = 0;
  logic [31:0] exp_r [$];
  logic [1:0]  exp_b [$];

  axi4lite_dht11_regs #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (5)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .sensor_data   (sensor_data),
    .sensor_valid  (sensor_valid),
    .sensor_err    (sensor_err),
    .ctrl          (ctrl)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every B or R handshake pops and checks the next expectation.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        b_seen++;
        compared++;
        if (exp_b.size() == 0) begin
          mismatched++;
          $display("FAIL bresp_unexpected: got %0h expected none", S_AXI_BRESP);
        end else begin
          logic [1:0] e;
          e = exp_b.pop_front();
          if (S_AXI_BRESP !== e) begin
            mismatched++;
            $display("FAIL bresp: got %0h expected %0h", S_AXI_BRESP, e);
          end
        end
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        r_seen++;
        compared++;
        if (exp_r.size() == 0) begin
          mismatched++;
          $display("FAIL rdata_unexpected: got %08h expected none", S_AXI_RDATA);
        end else begin
          logic [31:0] e;
          e = exp_r.pop_front();
          if (S_AXI_RDATA !== e || S_AXI_RRESP !== RESP_OKAY) begin
            mismatched++;
            $display("FAIL rdata: got %08h/%0h expected %08h/%0h",
                     S_AXI_RDATA, S_AXI_RRESP, e, RESP_OKAY);
          end
        end
      end
    end
  end

  // Drives AW and W together until both are accepted; returns just after the accept edge.
  task automatic issue_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_done;
    logic w_done;
    int unsigned n;
    aw_done = 1'b0;
    w_done  = 1'b0;
    n       = 0;
    @(posedge ACLK); #1;
    S_AXI_AWADDR = a;  S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA  = d;  S_AXI_WSTRB = s;  S_AXI_WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge ACLK);
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1'b1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1'b1;
      @(posedge ACLK); #1;
      if (aw_done) S_AXI_AWVALID = 1'b0;
      if (w_done)  S_AXI_WVALID  = 1'b0;
      n++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    if (!(aw_done && w_done)) begin
      compared++; mismatched++;
      $display("FAIL wr_accept_timeout: got aw=%0b w=%0b expected 1/1", aw_done, w_done);
    end
  endtask

  task automatic wait_b(input int unsigned start);
    int unsigned n;
    n = 0;
    while (b_seen == start && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (b_seen == start) begin
      compared++; mismatched++;
      $display("FAIL bvalid_timeout: got none expected response");
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned start;
    start = b_seen;
    exp_b.push_back(RESP_OKAY);
    issue_write(a, d, s);
    wait_b(start);
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] e);
    int unsigned start;
    int unsigned n;
    logic done;
    start = r_seen;
    n     = 0;
    done  = 1'b0;
    exp_r.push_back(e);
    @(posedge ACLK); #1;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    while (!done && n < 50) begin
      @(negedge ACLK);
      if (S_AXI_ARREADY) done = 1'b1;
      @(posedge ACLK); #1;
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (r_seen == start && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (r_seen == start) begin
      compared++; mismatched++;
      $display("FAIL rvalid_timeout: got none expected %08h", e);
    end
  endtask

  initial begin
    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    sensor_data = '0; sensor_valid = 1'b0; sensor_err = 1'b0;

    // Reset state
    repeat (2) @(negedge ACLK);
    check("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
    check("rst_wready",  {31'd0, S_AXI_WREADY},  32'd0);
    check("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
    check("rst_bvalid",  {31'd0, S_AXI_BVALID},  32'd0);
    check("rst_rvalid",  {31'd0, S_AXI_RVALID},  32'd0);
    check("rst_rdata",   S_AXI_RDATA, 32'd0);
    check("rst_ctrl",    ctrl, 32'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);

    // Write/readback of the four RW registers
    axi_write(5'h00, 32'h1, 4'hF);
    axi_write(5'h04, 32'h2, 4'hF);
    axi_write(5'h08, 32'h3, 4'hF);
    axi_write(5'h0C, 32'h4, 4'hF);
    axi_read(5'h00, 32'h0);
    axi_read(5'h04, 32'h2);
    axi_read(5'h08, 32'h3);
    axi_read(5'h0C, 32'h4);

    // CTRL bit0 visible on ctrl for exactly one cycle after the commit edge
    S_AXI_BREADY = 1'b0;
    begin
      int unsigned start;
      start = b_seen;
      exp_b.push_back(RESP_OKAY);
      issue_write(5'h00, 32'h0000_0A01, 4'hF);
      @(negedge ACLK);
      @(negedge ACLK);
      check("ctrl_pulse_hi", ctrl, 32'h0000_0A01);
      @(negedge ACLK);
      check("ctrl_pulse_lo", ctrl, 32'h0000_0A00);
      @(posedge ACLK); #1;
      S_AXI_BREADY = 1'b1;
      wait_b(start);
    end
    axi_read(5'h00, 32'h0000_0A00);

    // W three cycles ahead of AW, BREADY low for five cycles
    begin
      int unsigned start;
      start = b_seen;
      exp_b.push_back(RESP_OKAY);
      S_AXI_BREADY = 1'b0;
      @(posedge ACLK); #1;
      S_AXI_WDATA = 32'h1122_3344; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      @(negedge ACLK);
      check("wfirst_wready", {31'd0, S_AXI_WREADY}, 32'd1);
      @(posedge ACLK); #1;
      S_AXI_WVALID = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge ACLK);
        check("wfirst_wready_held", {31'd0, S_AXI_WREADY}, 32'd0);
        @(posedge ACLK); #1;
      end
      S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1'b1;
      @(negedge ACLK);
      check("wfirst_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0;
      @(negedge ACLK);
      check("wfirst_awready_held", {31'd0, S_AXI_AWREADY}, 32'd0);
      @(posedge ACLK); #1;
      for (int i = 0; i < 5; i++) begin
        @(negedge ACLK);
        check("wfirst_bvalid_hold", {29'd0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 32'd4);
        @(posedge ACLK); #1;
      end
      S_AXI_BREADY = 1'b1;
      wait_b(start);
    end
    axi_read(5'h04, 32'h1122_3344);

    // Byte strobes
    axi_write(5'h04, 32'hAABB_CCDD, 4'b0101);
    axi_read(5'h04, 32'h11BB_33DD);

    // Reserved words and read-only DATA ignore writes
    axi_write(5'h18, 32'hFFFF_FFFF, 4'hF);
    axi_write(5'h10, 32'hFFFF_FFFF, 4'hF);
    axi_read(5'h18, 32'h0);
    axi_read(5'h1C, 32'h0);
    axi_read(5'h10, 32'h0);

    // Sensor capture and W1C
    @(posedge ACLK); #1;
    sensor_data = 32'h2D00_1A05; sensor_valid = 1'b1;
    @(posedge ACLK); #1;
    sensor_valid = 1'b0;
    axi_read(5'h10, 32'h2D00_1A05);
    axi_read(5'h14, 32'h0001_0001);
    axi_write(5'h14, 32'h1, 4'hF);
    axi_read(5'h14, 32'h0001_0000);

    // W1C of bit0 colliding with a new frame: set wins, count advances
    begin
      int unsigned start;
      start = b_seen;
      exp_b.push_back(RESP_OKAY);
      @(posedge ACLK); #1;
      S_AXI_AWADDR = 5'h14; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      @(negedge ACLK);
      check("w1c_race_ready", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd3);
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      sensor_data = 32'h3000_1B02; sensor_valid = 1'b1;
      @(posedge ACLK); #1;
      sensor_valid = 1'b0;
      wait_b(start);
    end
    axi_read(5'h14, 32'h0002_0001);
    axi_read(5'h10, 32'h3000_1B02);

    // Error sticky and its W1C
    @(posedge ACLK); #1;
    sensor_err = 1'b1;
    @(posedge ACLK); #1;
    sensor_err = 1'b0;
    axi_read(5'h14, 32'h0002_0003);
    axi_write(5'h14, 32'h2, 4'hF);
    axi_read(5'h14, 32'h0002_0001);

    // Reset while BVALID is high
    S_AXI_BREADY = 1'b0;
    issue_write(5'h08, 32'hDEAD_BEEF, 4'hF);
    @(posedge ACLK); #1;
    check("pre_rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
    #2 ARESETN = 1'b0;
    #1;
    check("async_rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    S_AXI_BREADY = 1'b1;
    repeat (2) @(posedge ACLK);

    // Reset while RVALID is high
    axi_write(5'h0C, 32'h0000_0077, 4'hF);
    S_AXI_RREADY = 1'b0;
    @(posedge ACLK); #1;
    S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    check("pre_rst_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    check("pre_rst_rvalid", {S_AXI_RVALID, S_AXI_RDATA[30:0]}, 32'h8000_0077);
    #2 ARESETN = 1'b0;
    #1;
    check("async_rst_rvalid", {S_AXI_RVALID, S_AXI_RDATA[30:0]}, 32'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    S_AXI_RREADY = 1'b1;
    repeat (2) @(posedge ACLK);

    for (int i = 0; i < 8; i++) begin
      logic [4:0] a;
      a = 5'(i * 4);
      axi_read(a, 32'h0);
    end
    axi_write(5'h0C, 32'h5A5A_5A5A, 4'hF);
    axi_read(5'h0C, 32'h5A5A_5A5A);

    repeat (2) @(posedge ACLK);
    check("exp_r_drained", exp_r.size(), 32'd0);
    check("exp_b_drained", exp_b.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
